// File: rtl/sc_frogrow_shifter.sv
// One playfield row (frog position) with rate-limited left/right moves, clear and parallel load.
// Optional build macro SC_FROGROW_WRAP_EN: moves at the row edge rotate instead of blocking.
module sc_frogrow_shifter #(
    parameter int                   DATAWIDTH  = 8,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = 8'b00010000,
    parameter int                   COOLDOWN   = 4,
    parameter int                   CNTWIDTH   = 3
) (
    input  logic                 SC_FROGROW_CLOCK_50,
    input  logic                 SC_FROGROW_RESET_InLow,
    input  logic                 SC_FROGROW_clear_InLow,
    input  logic                 SC_FROGROW_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_FROGROW_data_InBUS,
    input  logic                 SC_FROGROW_shiftleft_InLow,
    input  logic                 SC_FROGROW_shiftright_InLow,
    output logic [DATAWIDTH-1:0] SC_FROGROW_data_OutBUS,
    output logic                 SC_FROGROW_busy_OutHigh,
    output logic                 SC_FROGROW_moved_OutHigh,
    output logic                 SC_FROGROW_edgehit_OutHigh
);

    localparam logic [CNTWIDTH-1:0] COOLDOWN_CNT = CNTWIDTH'(COOLDOWN);
    localparam logic [CNTWIDTH-1:0] CNT_ONE      = CNTWIDTH'(1);

    logic [CNTWIDTH-1:0] cooldownCnt;
    logic                reqLeft;
    logic                reqRight;
    logic                rowEmpty;

    // Exactly one request line low counts as a request; both low is a conflict.
    assign reqLeft  = ~SC_FROGROW_shiftleft_InLow & SC_FROGROW_shiftright_InLow;
    assign reqRight = ~SC_FROGROW_shiftright_InLow & SC_FROGROW_shiftleft_InLow;
    assign rowEmpty = (SC_FROGROW_data_OutBUS == '0);

    function automatic logic [CNTWIDTH-1:0] satDec(input logic [CNTWIDTH-1:0] c);
        return (c == '0) ? '0 : c - CNT_ONE;
    endfunction

    function automatic logic [DATAWIDTH-1:0] moveLeft(input logic [DATAWIDTH-1:0] d);
`ifdef SC_FROGROW_WRAP_EN
        return {d[DATAWIDTH-2:0], d[DATAWIDTH-1]};
`else
        return {d[DATAWIDTH-2:0], 1'b0};
`endif
    endfunction

    function automatic logic [DATAWIDTH-1:0] moveRight(input logic [DATAWIDTH-1:0] d);
`ifdef SC_FROGROW_WRAP_EN
        return {d[0], d[DATAWIDTH-1:1]};
`else
        return {1'b0, d[DATAWIDTH-1:1]};
`endif
    endfunction

    always_ff @(posedge SC_FROGROW_CLOCK_50 or negedge SC_FROGROW_RESET_InLow) begin
        if (!SC_FROGROW_RESET_InLow) begin
            SC_FROGROW_data_OutBUS     <= INIT_VALUE;
            cooldownCnt                <= '0;
            SC_FROGROW_busy_OutHigh    <= 1'b0;
            SC_FROGROW_moved_OutHigh   <= 1'b0;
            SC_FROGROW_edgehit_OutHigh <= 1'b0;
        end else begin
            SC_FROGROW_moved_OutHigh   <= 1'b0;
            SC_FROGROW_edgehit_OutHigh <= 1'b0;
            if (!SC_FROGROW_clear_InLow) begin
                SC_FROGROW_data_OutBUS  <= '0;
                cooldownCnt             <= '0;
                SC_FROGROW_busy_OutHigh <= 1'b0;
            end else if (!SC_FROGROW_load_InLow) begin
                SC_FROGROW_data_OutBUS  <= SC_FROGROW_data_InBUS;
                cooldownCnt             <= '0;
                SC_FROGROW_busy_OutHigh <= 1'b0;
            end else if (cooldownCnt != '0) begin
                // Requests during cooldown are dropped, not queued.
                cooldownCnt             <= satDec(cooldownCnt);
                SC_FROGROW_busy_OutHigh <= (cooldownCnt != CNT_ONE);
            end else if ((reqLeft || reqRight) && !rowEmpty) begin
                if ((reqLeft && SC_FROGROW_data_OutBUS[DATAWIDTH-1]) ||
                    (reqRight && SC_FROGROW_data_OutBUS[0])) begin
                    SC_FROGROW_edgehit_OutHigh <= 1'b1;
`ifdef SC_FROGROW_WRAP_EN
                    SC_FROGROW_data_OutBUS   <= reqLeft ? moveLeft(SC_FROGROW_data_OutBUS)
                                                        : moveRight(SC_FROGROW_data_OutBUS);
                    SC_FROGROW_moved_OutHigh <= 1'b1;
                    cooldownCnt              <= COOLDOWN_CNT;
                    SC_FROGROW_busy_OutHigh  <= (COOLDOWN_CNT != '0);
`endif
                end else begin
                    SC_FROGROW_data_OutBUS   <= reqLeft ? moveLeft(SC_FROGROW_data_OutBUS)
                                                        : moveRight(SC_FROGROW_data_OutBUS);
                    SC_FROGROW_moved_OutHigh <= 1'b1;
                    cooldownCnt              <= COOLDOWN_CNT;
                    SC_FROGROW_busy_OutHigh  <= (COOLDOWN_CNT != '0);
                end
            end
        end
    end

endmodule

// File: doc/sc_frogrow_shifter.md
Name: sc_frogrow_shifter

Overview:
- Holds one playfield row as a DATAWIDTH-bit pattern, normally the frog position as a one-hot bit.
- Moves the pattern left or right on player requests, rate-limited by a cooldown counter.
- Drives the row buses that feed the bottom-side comparator, which raises its flag when both rows are zero.
- Also accepts a synchronous clear and a parallel load, used by the game controller for respawn and level setup.

Parameters:
- DATAWIDTH, 8, row width in bits.
- INIT_VALUE, 8'b00010000, row contents after reset.
- COOLDOWN, 4, idle cycles forced after an accepted move. 0 means a move can be accepted every cycle.
- CNTWIDTH, 3, cooldown counter width. Must satisfy COOLDOWN ≤ 2^CNTWIDTH−1.

Ports:
- SC_FROGROW_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- SC_FROGROW_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_FROGROW_clear_InLow  in  1  synchronous clear; row becomes all zeros.
- SC_FROGROW_load_InLow  in  1  synchronous parallel load from data_InBUS.
- SC_FROGROW_data_InBUS  in  DATAWIDTH  load value.
- SC_FROGROW_shiftleft_InLow  in  1  move request toward the MSB, level-sensitive.
- SC_FROGROW_shiftright_InLow  in  1  move request toward the LSB, level-sensitive.
- SC_FROGROW_data_OutBUS  out  DATAWIDTH  registered row contents, fed to the comparator.
- SC_FROGROW_busy_OutHigh  out  1  high while the cooldown counter is nonzero.
- SC_FROGROW_moved_OutHigh  out  1  one-cycle pulse, registered with the data change.
- SC_FROGROW_edgehit_OutHigh  out  1  one-cycle pulse when a move is blocked at the row edge.

Behaviour:
- Reset (asynchronous, active-low; interrupts any operation immediately):
  - data_OutBUS=INIT_VALUE, counter=0, busy=0, moved=0, edgehit=0.
  - Operation resumes on the first rising edge after release.
- Priority, evaluated each rising edge: clear > load > move.
  - clear: data=0, counter=0, pulses=0.
  - load: data=data_InBUS, counter=0, pulses=0. The load value is taken as-is (not checked).
  - clear and load both asserted: clear wins.
- Move request:
  - A move is requested when exactly one of shiftleft/shiftright is low.
  - Both low, or both high: no request.
  - A request is accepted only when the counter is 0. Requests while the counter is nonzero are silently dropped; there is no queuing.
- Accepted left move:
  - If data[W−1]=1: data unchanged, edgehit=1 next cycle, counter not loaded.
  - Else: data<<1 with 0 shifted in, moved=1 next cycle, counter=COOLDOWN.
- Accepted right move: mirror of the left move, using data[0] and >>1.
- All-zero row: a request is a no-op. No pulses, counter untouched.
- Multi-bit patterns: the edge check uses only the outgoing end bit (bit W−1 for left, bit 0 for right).
- Cooldown counter:
  - Decrements by 1 each cycle while nonzero; saturates at 0.
  - busy is registered and equals (counter≠0).
- Latency and output timing:
  - Request sampled at edge N → data, moved and busy valid after edge N.
  - moved and edgehit are high for exactly one cycle and are never both high.
- Held request with COOLDOWN=4: moves occur at edges N, N+5, N+10, …
- COOLDOWN=0: busy stays 0 and a move can occur every cycle.

Optional Feature:
- Macro: SC_FROGROW_WRAP_EN.
- Defined:
  - A move at the edge rotates instead of blocking. Left: data[W−1] wraps to bit 0. Right: data[0] wraps to bit W−1.
  - The wrapping move asserts both moved and edgehit for that cycle and loads the counter.
  - The rule that moved and edgehit are never both high does not apply when the macro is defined.
- Undefined: the saturating/blocking behaviour above applies.

Test Plan:
- Reset: assert RESET_InLow=0 mid-cooldown (counter=3) → data=8'h10, busy=0, moved=0 immediately, without waiting for a clock edge.
- Cooldown timing: from 8'h10, hold shiftleft low for 12 cycles, COOLDOWN=4 → 8'h20 at edge 0, 8'h40 at edge 5, 8'h80 at edge 10. Three moved pulses; busy high for 4 cycles after each move.
- Edge block (macro off): load 8'h80, then shiftleft one cycle → data stays 8'h80, edgehit=1 for one cycle, moved=0, busy=0. Load 8'h01, then shiftright → same response at the LSB.
- Priority: clear, load(8'h3C) and shiftleft all low together → data=8'h00 and counter=0. Next cycle, load(8'h3C) and shiftright low together → data=8'h3C and no move.
- Conflict and empty row: both shift inputs low on 8'h10 → no change, no pulses. Clear to 8'h00, then shiftright → data=8'h00, no pulses, busy=0. The comparator input is therefore all zeros.
- Wrap (SC_FROGROW_WRAP_EN defined): load 8'h80, then shiftleft → data=8'h01, moved=1 and edgehit=1 in the same cycle, busy high for 4 cycles.
